// File: rtl/iecdrv_pkg.sv
// Shared types and constants for the iecdrv memory arbiter.
package iecdrv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Clocks from request ack to rvalid
  localparam int MEM_ARB_LAT = 4;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/iecdrv_rr_arb2.sv
// Two-way request picker: round-robin on last_gnt, or fixed priority to req0.
module iecdrv_rr_arb2
  import iecdrv_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  input  logic       mode,
  output logic [1:0] gnt_onehot
);

  always_comb begin
    gnt_onehot = 2'b00;
    case (valid)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      // On a tie, favour whoever was not served last unless req0 is fixed-priority
      2'b11:   gnt_onehot = ((mode == PRIO_FIXED) || last_gnt) ? 2'b01 : 2'b10;
      default: gnt_onehot = 2'b00;
    endcase
  end

endmodule

// File: rtl/iecdrv_mem_arb.sv
// Serialises two requesters onto one registered-address RAM port, 4 clocks per access.
module iecdrv_mem_arb
  import iecdrv_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 13,
  parameter int PRIO_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic                 req0_we,
  input  logic [ADDRWIDTH-1:0] req0_addr,
  input  logic [DATAWIDTH-1:0] req0_din,
  output logic                 req0_ack,
  output logic                 req0_rvalid,
  output logic [DATAWIDTH-1:0] req0_dout,
  input  logic                 req1_valid,
  input  logic                 req1_we,
  input  logic [ADDRWIDTH-1:0] req1_addr,
  input  logic [DATAWIDTH-1:0] req1_din,
  output logic                 req1_ack,
  output logic                 req1_rvalid,
  output logic [DATAWIDTH-1:0] req1_dout,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_din,
  output logic                 mem_wren,
  input  logic [DATAWIDTH-1:0] mem_q
);

  localparam logic ARB_MODE = (PRIO_MODE == 0) ? PRIO_RR : PRIO_FIXED;

  arb_state_t           state;
  logic                 gnt;
  logic                 last_gnt;
  logic                 we_p0;
  logic [1:0]           pick;
  logic                 grant;
  logic [DATAWIDTH-1:0] resp_data;

  iecdrv_rr_arb2 u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_gnt   (last_gnt),
    .mode       (ARB_MODE),
    .gnt_onehot (pick)
  );

  assign grant    = (state == IDLE) && !reset && (pick != 2'b00);
  assign req0_ack = grant && pick[0];
  assign req1_ack = grant && pick[1];

  // Writes echo the held write data; the RAM read port is not trusted for it
  assign resp_data = we_p0 ? mem_din : mem_q;

  // Grant edge: address/data are captured and held until the next grant,
  // deliberately outside reset so an in-flight write still commits intact data.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem_addr <= pick[1] ? req1_addr : req0_addr;
      mem_din  <= pick[1] ? req1_din  : req0_din;
      we_p0    <= pick[1] ? req1_we   : req0_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_wren    <= 1'b0;
      last_gnt    <= 1'b1;
      gnt         <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_dout   <= '0;
      req1_dout   <= '0;
    end else begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            gnt      <= pick[1];
            last_gnt <= pick[1];
            mem_wren <= pick[1] ? req1_we : req0_we;
            state    <= ADDR;
          end
        end
        // ADDR -> DATA: the RAM latches address/wren at this edge
        ADDR: begin
          mem_wren <= 1'b0;
          state    <= DATA;
        end
        // DATA -> RESP: write commits here, read data appears on mem_q
        DATA: state <= RESP;
        RESP: begin
          if (gnt) begin
            req1_rvalid <= 1'b1;
            req1_dout   <= resp_data;
          end else begin
            req0_rvalid <= 1'b1;
            req0_dout   <= resp_data;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iecdrv_mem_arb.sv
// Bench for iecdrv_mem_arb: round-robin and fixed-priority instances, each on its own RAM model.
module tb_iecdrv_mem_arb;
  import iecdrv_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic       v    [2][2];
  logic       we   [2][2];
  logic [12:0] addr[2][2];
  logic [7:0] din  [2][2];
  logic       ack  [2][2];
  logic       rv   [2][2];
  logic [7:0] dout [2][2];

  logic [12:0] maddr[2];
  logic [7:0]  mdin [2];
  logic        mwren[2];
  logic [7:0]  mq   [2];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  typedef struct {
    int         c;
    int         n;
    logic [7:0] d;
  } exp_t;

  exp_t sq  [2][$];
  int   glog[2][$];
  int   gcyc[2][$];
  exp_t e;

  iecdrv_mem_arb #(.DATAWIDTH(8), .ADDRWIDTH(13), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(v[0][0]), .req0_we(we[0][0]), .req0_addr(addr[0][0]), .req0_din(din[0][0]),
    .req0_ack(ack[0][0]), .req0_rvalid(rv[0][0]), .req0_dout(dout[0][0]),
    .req1_valid(v[0][1]), .req1_we(we[0][1]), .req1_addr(addr[0][1]), .req1_din(din[0][1]),
    .req1_ack(ack[0][1]), .req1_rvalid(rv[0][1]), .req1_dout(dout[0][1]),
    .mem_addr(maddr[0]), .mem_din(mdin[0]), .mem_wren(mwren[0]), .mem_q(mq[0])
  );

  iecdrv_mem_arb #(.DATAWIDTH(8), .ADDRWIDTH(13), .PRIO_MODE(1)) dut_fx (
    .clk(clk), .reset(reset),
    .req0_valid(v[1][0]), .req0_we(we[1][0]), .req0_addr(addr[1][0]), .req0_din(din[1][0]),
    .req0_ack(ack[1][0]), .req0_rvalid(rv[1][0]), .req0_dout(dout[1][0]),
    .req1_valid(v[1][1]), .req1_we(we[1][1]), .req1_addr(addr[1][1]), .req1_din(din[1][1]),
    .req1_ack(ack[1][1]), .req1_rvalid(rv[1][1]), .req1_dout(dout[1][1]),
    .mem_addr(maddr[1]), .mem_din(mdin[1]), .mem_wren(mwren[1]), .mem_q(mq[1])
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Preloaded RAM contents for locations never written
  function automatic logic [7:0] pre(input logic [12:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // RAM model: address/wren registered, data sampled and q updated one cycle later
  logic [12:0] ra[2];
  logic        rw[2];
  bit   [7:0]  ram[2][8192];
  bit          wrt[2][8192];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ra[k] <= maddr[k];
      rw[k] <= mwren[k];
      if (rw[k] === 1'b1) begin
        ram[k][ra[k]] <= mdin[k];
        wrt[k][ra[k]] <= 1'b1;
      end
      mq[k] <= wrt[k][ra[k]] ? ram[k][ra[k]] : pre(ra[k]);
    end
  end

  // Reference contents as seen by the bench
  bit [7:0] mdl[2][8192];
  bit       mwr[2][8192];

  // Scoreboard monitor
  always begin
    @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++) begin
      if (ack[k][0] === 1'b1 && ack[k][1] === 1'b1) begin
        tot_cnt++;
        $display("FAIL double_ack inst%0d: ack0=1 ack1=1, required at most one", k);
      end
      for (int n = 0; n < 2; n++) begin
        if (rv[k][n] === 1'b1) begin
          tot_cnt++;
          if (sq[k].size() == 0) begin
            $display("FAIL rvalid_unexpected inst%0d req%0d: dout=%h, required no rvalid", k, n, dout[k][n]);
          end else begin
            e = sq[k].pop_front();
            if (e.n != n || dout[k][n] !== e.d || (cyc - e.c) != MEM_ARB_LAT)
              $display("FAIL response inst%0d: got req%0d dout=%h lat=%0d, required req%0d dout=%h lat=%0d",
                       k, n, dout[k][n], cyc - e.c, e.n, e.d, MEM_ARB_LAT);
            else
              pass_cnt++;
          end
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (ack[k][n] === 1'b1) begin
          e.c = cyc;
          e.n = n;
          if (we[k][n]) begin
            e.d = din[k][n];
            mdl[k][addr[k][n]] = din[k][n];
            mwr[k][addr[k][n]] = 1'b1;
          end else begin
            e.d = mwr[k][addr[k][n]] ? mdl[k][addr[k][n]] : pre(addr[k][n]);
          end
          sq[k].push_back(e);
          glog[k].push_back(n);
          gcyc[k].push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input int k, input int n, input logic w, input logic [12:0] a, input logic [7:0] d);
    int t;
    we[k][n]   = w;
    addr[k][n] = a;
    din[k][n]  = d;
    v[k][n]    = 1'b1;
    for (t = 0; t < 60; t++) begin
      @(negedge clk);
      #2;
      if (ack[k][n] === 1'b1) break;
    end
    if (t == 60) begin
      tot_cnt++;
      $display("FAIL ack_timeout inst%0d req%0d: ack=0, required 1", k, n);
    end
    @(posedge clk);
    #1;
    v[k][n] = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int t = 0; t < 40 && sq[k].size() > 0; t++) @(posedge clk);
    tot_cnt++;
    if (sq[k].size() != 0)
      $display("FAIL drain inst%0d: %0d responses outstanding, required 0", k, sq[k].size());
    else
      pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_log(input int k);
    glog[k].delete();
    gcyc[k].delete();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    v[0][0]  = 1'b1;
    v[1][1]  = 1'b1;
    @(negedge clk);
    #2;
    tot_cnt++;
    if (ack[0][0] !== 1'b0 || ack[1][1] !== 1'b0)
      $display("FAIL reset_ack: ack=%b%b, required 00", ack[0][0], ack[1][1]);
    else
      pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    v[0][0] = 1'b0;
    v[1][1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tot_cnt++;
      if ({mwren[k], rv[k][0], rv[k][1], dout[k][0], dout[k][1]} !== 19'd0)
        $display("FAIL reset_state inst%0d: wren=%b rv=%b%b dout=%h/%h, required all 0",
                 k, mwren[k], rv[k][0], rv[k][1], dout[k][0], dout[k][1]);
      else
        pass_cnt++;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    do_reset();
    issue(0, 0, 1'b1, 13'h01A5, 8'h3C);
    drain(0);
    tot_cnt++;
    if (dout[0][0] !== 8'h3C) $display("FAIL write_echo: dout=%h, required 3c", dout[0][0]);
    else pass_cnt++;
    issue(0, 0, 1'b0, 13'h01A5, 8'h00);
    drain(0);
    tot_cnt++;
    if (dout[0][0] !== 8'h3C) $display("FAIL read_back: dout=%h, required 3c", dout[0][0]);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] got;
    int bad;
    do_reset();
    clear_log(0);
    fork
      begin for (int i = 0; i < 4; i++) issue(0, 0, 1'b0, 13'(32'h0010 + i), 8'h00); end
      begin for (int i = 0; i < 4; i++) issue(0, 1, 1'b0, 13'(32'h0020 + i), 8'h00); end
    join
    drain(0);
    got = '0;
    for (int i = 0; i < glog[0].size() && i < 8; i++) got[i] = glog[0][i][0];
    tot_cnt++;
    if (glog[0].size() != 8 || got !== 8'hAA)
      $display("FAIL rr_order: %0d grants pattern=%b, required 8 grants pattern=10101010", glog[0].size(), got);
    else
      pass_cnt++;
    bad = 0;
    for (int i = 1; i < gcyc[0].size(); i++) if (gcyc[0][i] - gcyc[0][i-1] != MEM_ARB_LAT) bad++;
    tot_cnt++;
    if (bad != 0) $display("FAIL rr_spacing: %0d gaps not 4 cycles, required 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_fixed_prio();
    logic [3:0] got;
    int gap;
    do_reset();
    clear_log(1);
    fork
      begin for (int i = 0; i < 3; i++) issue(1, 0, 1'b0, 13'(32'h0030 + i), 8'h00); end
      begin issue(1, 1, 1'b0, 13'h0040, 8'h00); end
    join
    drain(1);
    got = '0;
    for (int i = 0; i < glog[1].size() && i < 4; i++) got[i] = glog[1][i][0];
    tot_cnt++;
    if (glog[1].size() != 4 || got !== 4'b1000)
      $display("FAIL fixed_order: %0d grants pattern=%b, required 4 grants pattern=1000", glog[1].size(), got);
    else
      pass_cnt++;
    gap = (gcyc[1].size() == 4) ? gcyc[1][3] - gcyc[1][2] : -1;
    tot_cnt++;
    if (gap != MEM_ARB_LAT) $display("FAIL starve_release: gap=%0d, required 4", gap);
    else pass_cnt++;
  endtask

  task automatic test_owner();
    issue(0, 1, 1'b1, 13'h0000, 8'hFF);
    drain(0);
    issue(0, 0, 1'b0, 13'h1FFF, 8'h00);
    drain(0);
    tot_cnt++;
    if (dout[0][0] !== 8'hA5) $display("FAIL read_top: dout=%h, required a5", dout[0][0]);
    else pass_cnt++;
    issue(0, 0, 1'b0, 13'h0000, 8'h00);
    drain(0);
    tot_cnt++;
    if (dout[0][0] !== 8'hFF) $display("FAIL read_zero: dout=%h, required ff", dout[0][0]);
    else pass_cnt++;
    tot_cnt++;
    if (dout[0][1] !== 8'hFF) $display("FAIL req1_hold: dout=%h, required ff", dout[0][1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    issue(0, 0, 1'b1, 13'h0100, 8'h77);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    we[0][0]   = 1'b0;
    addr[0][0] = 13'h0100;
    v[0][0]    = 1'b1;
    tot_cnt++;
    if (sq[0].size() != 1) $display("FAIL abort_no_rvalid: %0d pending, required 1", sq[0].size());
    else pass_cnt++;
    if (sq[0].size() > 0) void'(sq[0].pop_front());
    @(negedge clk);
    #2;
    tot_cnt++;
    if (ack[0][0] !== 1'b1) $display("FAIL idle_after_reset: ack=%b, required 1", ack[0][0]);
    else pass_cnt++;
    @(posedge clk);
    #1;
    v[0][0] = 1'b0;
    drain(0);
    tot_cnt++;
    if (dout[0][0] !== 8'h77) $display("FAIL abort_commit: dout=%h, required 77", dout[0][0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic       w_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [12:0] a_t[4] = '{13'h0201, 13'h0201, 13'h0202, 13'h0200};
    logic [7:0] d_t [4] = '{8'h22, 8'h00, 8'h33, 8'h00};
    int span;
    bit seen;
    clear_log(0);
    issue(0, 0, 1'b1, 13'h0200, 8'h11);
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
        @(negedge clk);
        #1;
        seen = (rv[0][0] === 1'b1);
      end
      we[0][0]   = w_t[i];
      addr[0][0] = a_t[i];
      din[0][0]  = d_t[i];
      v[0][0]    = 1'b1;
      #1;
      tot_cnt++;
      if (!seen || ack[0][0] !== 1'b1)
        $display("FAIL ack_in_rvalid_cycle %0d: rvalid_seen=%b ack=%b, required 1 1", i, seen, ack[0][0]);
      else
        pass_cnt++;
      @(posedge clk);
      #1;
      v[0][0] = 1'b0;
    end
    drain(0);
    span = (gcyc[0].size() == 5) ? gcyc[0][4] - gcyc[0][0] : -1;
    tot_cnt++;
    if (span != 4 * MEM_ARB_LAT) $display("FAIL throughput: span=%0d, required 16", span);
    else pass_cnt++;
    tot_cnt++;
    if (dout[0][0] !== 8'h11) $display("FAIL b2b_last_read: dout=%h, required 11", dout[0][0]);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 2; n++) begin
        v[k][n] = 1'b0; we[k][n] = 1'b0; addr[k][n] = '0; din[k][n] = '0;
      end
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_owner();
    test_reset_abort();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
